// File: rtl/piano_pkg.sv
// Shared note/octave codes, C3 half-period table and tone FSM state encoding.
// Constants only; no latency, no backpressure.
package piano_pkg;

    localparam logic [3:0] NOTE_REST = 4'd0;
    localparam logic [3:0] NOTE_DO   = 4'd1;
    localparam logic [3:0] NOTE_RE   = 4'd2;
    localparam logic [3:0] NOTE_MI   = 4'd3;
    localparam logic [3:0] NOTE_FA   = 4'd4;
    localparam logic [3:0] NOTE_SOL  = 4'd5;
    localparam logic [3:0] NOTE_LA   = 4'd6;
    localparam logic [3:0] NOTE_SI   = 4'd7;

    localparam logic [1:0] OCT_LOW     = 2'd0;
    localparam logic [1:0] OCT_MID     = 2'd1;
    localparam logic [1:0] OCT_HIGH    = 2'd2;
    localparam logic [1:0] OCT_HIGHEST = 2'd3;

    localparam int HP_W = 19;

    // Half-periods in 100 MHz clk cycles for the C3-based octave.
    localparam logic [HP_W-1:0] HP_DO  = 19'd382233;
    localparam logic [HP_W-1:0] HP_RE  = 19'd340530;
    localparam logic [HP_W-1:0] HP_MI  = 19'd303379;
    localparam logic [HP_W-1:0] HP_FA  = 19'd286353;
    localparam logic [HP_W-1:0] HP_SOL = 19'd255102;
    localparam logic [HP_W-1:0] HP_LA  = 19'd227273;
    localparam logic [HP_W-1:0] HP_SI  = 19'd202478;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        PLAY = 2'd2
    } state_e;

    function automatic logic [HP_W-1:0] half_period_c3(input logic [3:0] note);
        case (note)
            NOTE_DO:  return HP_DO;
            NOTE_RE:  return HP_RE;
            NOTE_MI:  return HP_MI;
            NOTE_FA:  return HP_FA;
            NOTE_SOL: return HP_SOL;
            NOTE_LA:  return HP_LA;
            NOTE_SI:  return HP_SI;
            default:  return '0;
        endcase
    endfunction

    function automatic logic note_is_tone(input logic [3:0] note);
        return (note >= NOTE_DO) && (note <= NOTE_SI);
    endfunction

endpackage

// File: rtl/note_to_half_period.sv
// Maps note/octave/shift to a square-wave half-period in clk cycles, clamped to >= 2.
// Purely combinational (zero latency); no backpressure.
module note_to_half_period
    import piano_pkg::*;
(
    input  logic [3:0]      note,
    input  logic [1:0]      octave,
    input  logic [4:0]      shift,
    output logic [HP_W-1:0] hp
);

    logic [HP_W-1:0] base;
    logic [HP_W-1:0] shifted;
    logic [5:0]      shamt;

    always_comb begin
        base    = half_period_c3(note);
        shamt   = {1'b0, shift} + {4'b0000, octave};
        shifted = base >> shamt;
        // A half-period below 2 would make the reload counter degenerate.
        hp      = (shifted < 19'd2) ? 19'd2 : shifted;
    end

endmodule

// File: rtl/tone_generator.sv
// Square-wave buzzer driver with a silent articulation gap on every note change.
// First rising edge GAP_CYCLES after the change edge; no backpressure (free-running output).
module tone_generator
    import piano_pkg::*;
#(
    parameter int GAP_CYCLES = 5_000_000,
    parameter int HP_SHIFT   = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] note,
    input  logic [1:0] octave,
    output logic       speaker,
    output logic       playing
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

    state_e          state_q, state_d;
    logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
    logic [HP_W-1:0] hp_cnt_q, hp_cnt_d;
    logic [3:0]      note_q, note_d;
    logic [1:0]      oct_q, oct_d;
    logic            valid_q, valid_d;
    logic            speaker_q, speaker_d;
    logic            playing_q, playing_d;

    logic            valid;
    logic            change;
    logic [HP_W-1:0] hp;

    note_to_half_period u_hp (
        .note   (note_q),
        .octave (oct_q),
        .shift  (5'(HP_SHIFT)),
        .hp     (hp)
    );

    assign valid  = enable && note_is_tone(note);
    // A rest-to-note transition retriggers even when the note matches the latched one.
    assign change = valid && (!valid_q || (note != note_q) || (octave != oct_q));

    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        hp_cnt_d  = hp_cnt_q;
        note_d    = note_q;
        oct_d     = oct_q;
        speaker_d = speaker_q;
        valid_d   = valid;

        if (!valid) begin
            state_d   = IDLE;
            speaker_d = 1'b0;
            gap_cnt_d = '0;
            hp_cnt_d  = '0;
        end else if (change) begin
            state_d   = GAP;
            speaker_d = 1'b0;
            gap_cnt_d = GAP_LOAD;
            note_d    = note;
            oct_d     = octave;
        end else begin
            case (state_q)
                GAP: begin
                    if (gap_cnt_q == '0) begin
                        state_d   = PLAY;
                        speaker_d = 1'b1;
                        hp_cnt_d  = hp - 19'd1;
                    end else begin
                        gap_cnt_d = gap_cnt_q - 1'b1;
                    end
                end
                PLAY: begin
                    if (hp_cnt_q == '0) begin
                        speaker_d = ~speaker_q;
                        hp_cnt_d  = hp - 19'd1;
                    end else begin
                        hp_cnt_d  = hp_cnt_q - 19'd1;
                    end
                end
                default: ;
            endcase
        end

        playing_d = (state_d == PLAY);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            gap_cnt_q <= '0;
            hp_cnt_q  <= '0;
            note_q    <= NOTE_REST;
            oct_q     <= OCT_LOW;
            valid_q   <= 1'b0;
            speaker_q <= 1'b0;
            playing_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            hp_cnt_q  <= hp_cnt_d;
            note_q    <= note_d;
            oct_q     <= oct_d;
            valid_q   <= valid_d;
            speaker_q <= speaker_d;
            playing_q <= playing_d;
        end
    end

    assign speaker = speaker_q;
    assign playing = playing_q;

endmodule

// File: tb/tb_tone_generator.sv
// Bench for tone_generator: timeline reference model plus directed pitch/gap/reset checks and random notes.
module tb_tone_generator;
    import piano_pkg::*;

    localparam int G  = 8;
    localparam int SH = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [3:0] note = NOTE_REST;
    logic [1:0] octave = OCT_LOW;
    logic       speaker;
    logic       playing;

    int pass_cnt = 0;
    int total_cnt = 0;

    tone_generator #(.GAP_CYCLES(G), .HP_SHIFT(SH)) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .note    (note),
        .octave  (octave),
        .speaker (speaker),
        .playing (playing)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int model_hp(input int n, input int o);
        int base [0:7];
        int v;
        base = '{0, 382233, 340530, 303379, 286353, 255102, 227273, 202478};
        if (n < 1 || n > 7) return 2;
        v = base[n] >> (o + SH);
        return (v < 2) ? 2 : v;
    endfunction

    // Reference: outputs are a function of time elapsed since the last change event.
    int cyc = 0, t0 = 0, mhp = 2, ln = 0, lo = 0, k;
    bit act = 0, pv = 0, v;
    bit exp_spk = 0, exp_ply = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            act = 0; pv = 0; exp_spk = 0; exp_ply = 0;
        end else begin
            cyc++;
            v = enable && (note >= 1) && (note <= 7);
            if (!v) act = 0;
            else if (!pv || int'(note) != ln || int'(octave) != lo) begin
                act = 1; t0 = cyc; mhp = model_hp(note, octave);
                ln = note; lo = octave;
            end
            pv = v;
            k = cyc - t0;
            exp_ply = act && (k >= G);
            exp_spk = exp_ply && ((((k - G) / mhp) % 2) == 0);
        end
    end

    always @(negedge clk) begin
        check("speaker", speaker, exp_spk);
        check("playing", playing, exp_ply);
    end

    task automatic measure_tone(input int exp_hp);
        int n, m;
        n = 0;
        do begin @(negedge clk); n++; end while (!speaker && n < 200);
        check("rise_delay", n - 1, G);
        m = 0;
        while (speaker && m < 2000) begin @(negedge clk); m++; end
        check("high_phase", m, exp_hp);
        m = 0;
        while (!speaker && m < 2000) begin @(negedge clk); m++; end
        check("low_phase", m, exp_hp);
    endtask

    initial begin
        int drops, n, hold, r;

        check("model_hp_do_low", model_hp(1, 0), 373);
        check("model_hp_do_mid", model_hp(1, 1), 186);
        check("model_hp_la_low", model_hp(6, 0), 221);
        check("model_hp_re_high", model_hp(2, 2), 83);

        enable = 1'b1;
        #3 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_speaker", speaker, 0);
        check("reset_playing", playing, 0);
        reset = 1'b1;
        repeat (1000) @(negedge clk);

        note = NOTE_DO; octave = OCT_LOW;
        measure_tone(373);
        check("playing_in_tone", playing, 1);
        octave = OCT_MID;
        measure_tone(186);
        note = NOTE_LA; octave = OCT_LOW;
        measure_tone(221);

        note = NOTE_MI;
        measure_tone(296);
        drops = 0;
        repeat (5000) begin @(negedge clk); if (!playing) drops++; end
        check("hold_no_retrigger", drops, 0);

        note = NOTE_REST;
        @(negedge clk);
        check("rest_playing", playing, 0);
        check("rest_speaker", speaker, 0);
        note = NOTE_MI;
        measure_tone(296);

        note = 4'd9;
        @(negedge clk);
        check("invalid_playing", playing, 0);
        check("invalid_speaker", speaker, 0);

        note = NOTE_RE; octave = OCT_HIGH;
        n = 0;
        do begin @(negedge clk); n++; end while (!speaker && n < 200);
        check("pre_disable_speaker", speaker, 1);
        enable = 1'b0;
        @(posedge clk); #1;
        check("disable_speaker", speaker, 0);
        check("disable_playing", playing, 0);
        @(negedge clk);
        enable = 1'b1;
        measure_tone(83);

        repeat (50) @(negedge clk);
        check("pre_reset_playing", playing, 1);
        #2 reset = 1'b0;
        #1;
        check("async_reset_speaker", speaker, 0);
        check("async_reset_playing", playing, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        measure_tone(83);

        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            r = $urandom_range(0, 9);
            if (r < 7) note = 4'(r + 1);
            else if (r == 7) note = NOTE_REST;
            else note = 4'($urandom_range(8, 15));
            octave = 2'($urandom_range(0, 3));
            enable = ($urandom_range(0, 7) != 0);
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : $urandom_range(20, 900);
            repeat (hold) @(negedge clk);
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/tone_generator.md
Name: tone_generator

Overview:
Downstream stage of the piano controller. Consumes the selected note code and octave, and drives the buzzer pin with a square wave at the pitch of that note. Inserts a short silent articulation gap on every note change, so repeated or adjacent notes are audibly separated. One instance sits between the controller and the speaker output pin.

Parameters:
GAP_CYCLES, 5_000_000, length of the silent gap inserted on each note or octave change, in clk cycles (50 ms at 100 MHz).
HP_SHIFT, 0, extra right-shift applied to every half-period; nonzero only for simulation speed-up.

Ports:
clk  in  1  system clock, 100 MHz
reset  in  1  asynchronous, active-low reset
enable  in  1  1 = sound allowed; 0 = forced silence
note  in  4  0 = rest, 1..7 = do..si, 8..15 = invalid and treated as rest
octave  in  2  0 = low (C3 base), 1 = middle, 2 = high, 3 = highest
speaker  out  1  square-wave drive to buzzer
playing  out  1  1 while in PLAY state

Behaviour:
- Reset (reset=0, async): state=IDLE, speaker=0, playing=0, counters=0, latched note/octave=0.
- Half-period table (clk cycles, 100 MHz), indexed by note 1..7: 382233, 340530, 303379, 286353, 255102, 227273, 202478.
- hp = TABLE[note] >> (octave + HP_SHIFT), computed in 19 bits. If hp < 2, hp is clamped to 2.
- Sound request: valid = enable && note in 1..7.
- Change event: valid is 1 and {note,octave} differs from the latched {note_q,oct_q}, or valid rises from 0. The event is detected combinationally and acted on at the same clock edge; note_q/oct_q are updated at that edge.
- States:
  - IDLE: speaker=0, playing=0. On a change event, load gap_cnt = GAP_CYCLES-1 and go to GAP.
  - GAP: speaker=0, playing=0. gap_cnt decrements each cycle. At 0: go to PLAY, set speaker=1, load hp_cnt = hp-1.
  - PLAY: playing=1. hp_cnt decrements each cycle. At 0: toggle speaker and reload hp-1. Output period = 2*hp cycles, duty 50%.
- Priority:
  1. !valid forces IDLE on the next edge from any state; speaker=0 immediately at that edge.
  2. A change event in GAP or PLAY restarts GAP (gap reloaded, speaker=0).
  3. Otherwise, normal counting.
- Holding the same note/octave never retriggers. A note released to rest and then re-pressed is a change event.
- Timing: first speaker rising edge occurs exactly GAP_CYCLES cycles after the event edge.
- GAP_CYCLES=0 is not supported; minimum is 1.
- enable low in mid-note behaves as a rest. Re-enable with the same note retriggers via gap.

Decomposition:
- Package piano_pkg:
  - note code constants NOTE_REST, NOTE_DO..NOTE_SI
  - octave constants
  - HALF_PERIOD_C3 table as 7 localparams of 19 bits
  - state encoding IDLE/GAP/PLAY
- One sub-module is natural: note_to_half_period (combinational: note, octave, shift -> hp, with clamp). The FSM and counters stay in tone_generator.

Test Plan:
- Reset then idle: reset=0 for 3 cycles, then 1, note=0 -> speaker=0 and playing=0 for 1000 cycles.
- Basic pitch: HP_SHIFT=10, GAP_CYCLES=8; note=1, octave=0 -> speaker rises 8 cycles after the event; high/low phases of 373 cycles each; playing=1.
- Octave scaling: same setup with octave=1 -> half-period 186; then note=6, octave=0 -> 8-cycle gap (speaker=0), then half-period 221.
- Retrigger and hold: note=3 held for 5000 cycles -> exactly one gap at start. Note 3 -> 0 for 1 cycle -> 3 again -> IDLE, then a fresh 8-cycle gap before the first rising edge.
- Invalid/disable: note=9 -> IDLE, speaker=0. In PLAY, drop enable with speaker=1 -> speaker=0 at the next edge, playing=0.
- Async reset mid-note: assert reset between clock edges during PLAY -> speaker=0 and playing=0 immediately, with no clock edge. After release with note unchanged -> treated as a change event, gap, then tone.
